// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// Pure wiring; no storage and no added latency.
// Backpressure is by holding req_valid / mem_req until the matching ack.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          req_err;
    logic [DATA_WIDTH-1:0]         req_rdata;

    // Memory controller side
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic                          mem_we;
    logic                          mem_req;
    logic                          mem_ack;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    // Status
    logic [GW-1:0]                 grant_id;
    logic                          busy;

    // Arbiter view
    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, mem_ack, mem_rdata,
        output req_ack, req_err, req_rdata, mem_addr, mem_wdata, mem_we,
               mem_req, grant_id, busy
    );

    // Environment view: requesters plus memory controller
    modport master (
        output req_valid, req_addr, req_wdata, req_we, mem_ack, mem_rdata,
        input  req_ack, req_err, req_rdata, mem_addr, mem_wdata, mem_we,
               mem_req, grant_id, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request port among NUM_REQ requesters.
// Latency: mem_req one cycle after req_valid is sampled; req_ack one cycle after mem_ack.
// Backpressure: one transaction in flight; losers hold req_valid until their own req_ack.
module mem_port_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST   = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [GW-1:0]           last_grant_q;
    logic [GW-1:0]           grant_id_q;
    logic [CW-1:0]           tmo_cnt_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    mem_we_q;
    logic                    mem_req_q;
    logic [NUM_REQ-1:0]      req_ack_q;
    logic                    req_err_q;
    logic [DATA_WIDTH-1:0]   req_rdata_q;

    logic [NUM_REQ-1:0]      req_rot_d;
    logic                    win_vld_d;
    logic [GW-1:0]           win_d;
    logic [ADDR_WIDTH-1:0]   win_addr_d;
    logic [DATA_WIDTH-1:0]   win_wdata_d;
    logic                    win_we_d;

    // Round-robin pick: rotate requests so bit 0 is the requester just after
    // the last winner, then take the lowest set bit of the rotated vector.
    always_comb begin
        req_rot_d = NUM_REQ'({bus.req_valid, bus.req_valid} >> (int'(last_grant_q) + 1));
        win_vld_d = |bus.req_valid;
        win_d     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot_d[j]) begin
                win_d = GW'((int'(last_grant_q) + 1 + j) % NUM_REQ);
            end
        end
    end

    // Mux only the winner's slice toward the memory port.
    always_comb begin
        win_addr_d  = '0;
        win_wdata_d = '0;
        win_we_d    = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_d == GW'(j)) begin
                win_addr_d  = bus.req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata_d = bus.req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
                win_we_d    = bus.req_we[j];
            end
        end
    end

    // Control FSM with all outputs registered; reset aborts any transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_INIT;
            grant_id_q   <= '0;
            tmo_cnt_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            req_ack_q    <= '0;
            req_err_q    <= 1'b0;
            req_rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // mem_ack here is stray and deliberately ignored.
                    req_ack_q <= '0;
                    req_err_q <= 1'b0;
                    if (win_vld_d) begin
                        mem_addr_q   <= win_addr_d;
                        mem_wdata_q  <= win_wdata_d;
                        mem_we_q     <= win_we_d;
                        mem_req_q    <= 1'b1;
                        grant_id_q   <= win_d;
                        last_grant_q <= win_d;
                        tmo_cnt_q    <= '0;
                        state_q      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A real ack takes priority over a timeout expiring on the same cycle.
                    if (bus.mem_ack) begin
                        req_rdata_q <= bus.mem_rdata;
                        req_ack_q   <= NUM_REQ'(1) << grant_id_q;
                        req_err_q   <= 1'b0;
                        mem_req_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else if ((TIMEOUT_CYCLES > 0) && (tmo_cnt_q == TO_LAST)) begin
                        req_rdata_q <= '0;
                        req_ack_q   <= NUM_REQ'(1) << grant_id_q;
                        req_err_q   <= 1'b1;
                        mem_req_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    // The acked requester still shows req_valid this cycle, so no arbitration.
                    req_ack_q <= '0;
                    req_err_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    req_ack_q <= '0;
                    req_err_q <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.req_ack   = req_ack_q;
    assign bus.req_err   = req_err_q;
    assign bus.req_rdata = req_rdata_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q != S_IDLE);

    // Completion pulses are one-hot and confined to the response cycle.
    ack_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ack));
    ack_in_resp_a: assert property (@(posedge clk) disable iff (rst)
                                    (bus.req_ack != '0) |-> (state_q == S_RESP));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL rst_req_ack: got %b want 00", bus.req_ack); end
        checks++; if (bus.req_err !== 1'b0) begin errors++; $display("FAIL rst_req_err: got %b want 0", bus.req_err); end
        checks++; if (bus.req_rdata !== 32'h0) begin errors++; $display("FAIL rst_req_rdata: got %h want 0", bus.req_rdata); end
        checks++; if (bus.grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant_id: got %b want 0", bus.grant_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_bus: got addr %h we %b want 0/0", bus.mem_addr, bus.mem_we); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        bus.req_addr[31:0] = 32'h0000_0100;
        bus.req_we         = 2'b00;
        bus.req_valid      = 2'b01;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rd_issue: got req %b addr %h we %b want 1/100/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
        checks++; if (bus.grant_id !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rd_grant: got id %b busy %b want 0/1", bus.grant_id, bus.busy); end
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.req_ack !== 2'b00) begin errors++; $display("FAIL rd_hold2: got req %b ack %b want 1/00", bus.mem_req, bus.req_ack); end
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL rd_hold3: got req %b addr %h want 1/100", bus.mem_req, bus.mem_addr); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack   = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || bus.req_ack !== 2'b01) begin errors++; $display("FAIL rd_ack: got req %b ack %b want 0/01", bus.mem_req, bus.req_ack); end
        checks++; if (bus.req_rdata !== 32'hDEAD_BEEF || bus.req_err !== 1'b0) begin errors++; $display("FAIL rd_data: got %h err %b want deadbeef/0", bus.req_rdata, bus.req_err); end
        bus.req_valid = 2'b00;
        tick();
        checks++; if (bus.req_ack !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rd_end: got ack %b busy %b want 00/0", bus.req_ack, bus.busy); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_ack;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_addr  = {32'h0000_0020, 32'h0000_0010};
        bus.req_we    = 2'b00;
        bus.req_valid = 2'b11;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_00AA;
        for (int g = 0; g < 4; g++) begin
            exp_ack = (g % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++; if (bus.mem_req !== 1'b1 || bus.grant_id !== 1'(g % 2)) begin errors++; $display("FAIL cont_grant%0d: got req %b id %b want 1/%0d", g, bus.mem_req, bus.grant_id, g % 2); end
            checks++; if (bus.mem_addr !== ((g % 2 == 0) ? 32'h10 : 32'h20)) begin errors++; $display("FAIL cont_addr%0d: got %h", g, bus.mem_addr); end
            tick();
            checks++; if (bus.req_ack !== exp_ack || bus.mem_req !== 1'b0) begin errors++; $display("FAIL cont_ack%0d: got ack %b req %b want %b/0", g, bus.req_ack, bus.mem_req, exp_ack); end
            tick();
            checks++; if (bus.req_ack !== 2'b00 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL cont_gap%0d: got ack %b req %b want 00/0", g, bus.req_ack, bus.mem_req); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write();
        bus.req_addr  = {32'h0000_0040, 32'h0000_0999};
        bus.req_wdata = {32'h1234_5678, 32'hFFFF_FFFF};
        bus.req_we    = 2'b10;
        bus.req_valid = 2'b10;
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1234_5678 || bus.mem_addr !== 32'h40) begin errors++; $display("FAIL wr_issue: got we %b wdata %h addr %h want 1/12345678/40", bus.mem_we, bus.mem_wdata, bus.mem_addr); end
        checks++; if (bus.grant_id !== 1'b1) begin errors++; $display("FAIL wr_grant: got %b want 1", bus.grant_id); end
        bus.req_wdata[63:32] = 32'h0BAD_0BAD;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_wdata !== 32'h1234_5678 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_stable: got req %b wdata %h we %b", bus.mem_req, bus.mem_wdata, bus.mem_we); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.req_ack !== 2'b10 || bus.req_err !== 1'b0) begin errors++; $display("FAIL wr_ack: got ack %b err %b want 10/0", bus.req_ack, bus.req_err); end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        bus.mem_rdata      = 32'hCAFE_F00D;
        bus.req_addr[31:0] = 32'h0000_0200;
        bus.req_valid      = 2'b01;
        tick();
        n = 0;
        for (int c = 0; c < 12 && bus.mem_req === 1'b1; c++) begin
            n++;
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", n); end
        checks++; if (bus.req_ack !== 2'b01 || bus.req_err !== 1'b1) begin errors++; $display("FAIL to_ack: got ack %b err %b want 01/1", bus.req_ack, bus.req_err); end
        checks++; if (bus.req_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", bus.req_rdata); end
        bus.req_valid = 2'b00;
        tick();
        checks++; if (bus.req_err !== 1'b0 || bus.req_ack !== 2'b00) begin errors++; $display("FAIL to_clear: got ack %b err %b want 00/0", bus.req_ack, bus.req_err); end
        bus.req_addr[63:32] = 32'h0000_0080;
        bus.req_valid       = 2'b10;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin errors++; $display("FAIL to_next_issue: got req %b addr %h want 1/80", bus.mem_req, bus.mem_addr); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_55AA;
        tick();
        bus.mem_ack   = 1'b0;
        checks++; if (bus.req_ack !== 2'b10 || bus.req_err !== 1'b0 || bus.req_rdata !== 32'h55AA) begin errors++; $display("FAIL to_next_ack: got ack %b err %b data %h want 10/0/55aa", bus.req_ack, bus.req_err, bus.req_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_ack_at_expiry();
        bus.req_addr[31:0] = 32'h0000_0300;
        bus.req_valid      = 2'b01;
        tick(); tick(); tick(); tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL exp_pre: got req %b want 1", bus.mem_req); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_CAFE;
        tick();
        bus.mem_ack   = 1'b0;
        checks++; if (bus.req_ack !== 2'b01 || bus.req_err !== 1'b0 || bus.req_rdata !== 32'h0BAD_CAFE) begin errors++; $display("FAIL exp_ack: got ack %b err %b data %h want 01/0/0badcafe", bus.req_ack, bus.req_err, bus.req_rdata); end
        bus.req_valid = 2'b00;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        tick();
        checks++; if (bus.req_ack !== 2'b00 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stray_ack: got ack %b req %b busy %b want 00/0/0", bus.req_ack, bus.mem_req, bus.busy); end
        checks++; if (bus.req_rdata !== 32'h0BAD_CAFE) begin errors++; $display("FAIL stray_rdata: got %h want 0badcafe", bus.req_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req_addr  = {32'h0000_0A10, 32'h0000_0A00};
        bus.req_valid = 2'b01;
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rm_busy: got req %b want 1", bus.mem_req); end
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.req_ack !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rm_async: got req %b ack %b busy %b want 0/00/0", bus.mem_req, bus.req_ack, bus.busy); end
        bus.req_valid = 2'b10;
        #1;
        rst = 1'b0;
        tick();
        checks++; if (bus.grant_id !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hA10) begin errors++; $display("FAIL rm_req1: got id %b req %b addr %h want 1/1/a10", bus.grant_id, bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.req_ack !== 2'b10) begin errors++; $display("FAIL rm_req1_ack: got %b want 10", bus.req_ack); end
        bus.req_valid = 2'b00;
        tick();
        rst = 1'b1;
        #1;
        bus.req_valid = 2'b11;
        #1;
        rst = 1'b0;
        tick();
        checks++; if (bus.grant_id !== 1'b0 || bus.mem_addr !== 32'hA00) begin errors++; $display("FAIL rm_both: got id %b addr %h want 0/a00", bus.grant_id, bus.mem_addr); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.req_ack !== 2'b01) begin errors++; $display("FAIL rm_both_ack: got %b want 01", bus.req_ack); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single CPU-side memory request port (addr/wdata/we/req/ack) between NUM_REQ requesters, e.g. instruction fetch and load/store.
- Round-robin arbitration, one outstanding transaction at a time, registered outputs.
- Per-transaction timeout returns an error to the requester if the memory controller never acks.
- Sits between the CPU pipeline masters and the memory controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 64, maximum cycles mem_req is held without mem_ack; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request; held until the matching req_ack.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data.
- req_we  input  NUM_REQ  write enable per requester.
- req_ack  output  NUM_REQ  one-cycle completion pulse, one-hot.
- req_err  output  1  valid with req_ack; 1 means timeout, no memory access completed.
- req_rdata  output  DATA_WIDTH  read data, shared, valid with req_ack.
- mem_addr  output  ADDR_WIDTH  to memory controller.
- mem_wdata  output  DATA_WIDTH  to memory controller.
- mem_we  output  1  to memory controller.
- mem_req  output  1  to memory controller; held until mem_ack.
- mem_ack  input  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  input  DATA_WIDTH  read data.
- grant_id  output  max(1,$clog2(NUM_REQ))  index of the current or last winner.
- busy  output  1  high in BUSY and RESP.

Behaviour:
- Reset (async assert): state=IDLE. All outputs are 0, including grant_id. last_grant=NUM_REQ-1, so requester 0 wins first. Timeout counter=0.
- Reset mid-transaction: mem_req drops immediately and no req_ack is issued. The requester re-arbitrates after reset release.

State machine (IDLE, BUSY, RESP):
- **IDLE:** if any req_valid, pick the winner w as the first asserted index searching from (last_grant+1) mod NUM_REQ upward with wrap. Register mem_addr/mem_wdata/mem_we from slice w, set mem_req=1, grant_id=w, last_grant=w, and go to BUSY. With no requests, stay in IDLE; mem_* hold their previous values and mem_req=0.
- **BUSY:** mem_req=1 and all mem_* outputs are stable.
  - On mem_ack: capture mem_rdata into req_rdata, pulse req_ack[w]=1 with req_err=0 next cycle, drop mem_req next cycle, go to RESP.
  - Else, if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1: drop mem_req, pulse req_ack[w] with req_err=1, leave req_rdata at 0, go to RESP.
  - The counter increments every BUSY cycle and clears on entry to BUSY.
- **RESP:** req_ack is high this cycle only. No arbitration here, because the acked requester's req_valid is still high. Go to IDLE next cycle.

Timing and boundary rules:
- Latency: req_valid sampled at edge N → mem_req high after edge N. mem_ack sampled at edge M → req_ack high after edge M. Minimum request-to-ack is 2 cycles; back-to-back grants are 3 cycles apart.
- Simultaneous mem_ack and timeout expiry: mem_ack wins and req_err=0.
- mem_ack in IDLE or RESP is ignored, with no output change.
- A request dropping while granted is a protocol violation. The transaction still completes and the ack is still issued to w.
- req_valid changes during BUSY do not affect the current grant.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,…,NUM_REQ-1,0; each waits at most NUM_REQ-1 transactions.
- Non-winner slices are never forwarded; req_ack and req_err are 0 outside RESP.

Test Plan:
- Single read: req_valid=2'b01, addr=0x100, we=0; memory acks 3 cycles after mem_req with rdata=0xDEADBEEF → mem_addr=0x100, mem_req high 3 cycles, req_ack=2'b01 one cycle later with req_rdata=0xDEADBEEF, req_err=0.
- Contention: both requesters assert from reset with immediate ack → grant order 0,1,0,1. Each req_ack is one-hot and one cycle wide; grants are 3 cycles apart.
- Write pass-through: requester 1 with we=1, addr=0x40, wdata=0x12345678 → mem_we=1 and mem_wdata=0x12345678 stable until mem_ack; grant_id=1.
- Timeout: TIMEOUT_CYCLES=4, memory never acks → mem_req high exactly 4 cycles, then req_ack pulses with req_err=1 and req_rdata=0. A second request then proceeds normally.
- Ack on the timeout-expiry cycle → req_err=0 and req_rdata equals mem_rdata. A stray mem_ack in IDLE produces no req_ack.
- Assert rst during BUSY → mem_req=0 asynchronously with no req_ack. After release, with requester 1 pending, requester 1 is granted; with both requesters pending, requester 0 wins.
